game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Central game-state controller for the stacker game, replacing the ad hoc
//  "stop = end_game | pause" glue in the top level. Runs the IDLE/PLAY/PAUSE/OVER
//  state machine, the round countdown timer and the score accumulator.
//  Drives the shared stop/clear controls for the falling-item, stack and display
//  blocks. Generalised to NUM_ITEMS falling channels with per-colour score weights.
// PARAMETERS
//  NUM_ITEMS   1   number of falling-item channels (1..8)
//  SCORE_W     7   score width in bits; score saturates at 2**SCORE_W-1
//  ROUND_SECS  60  round length in seconds, decimal 1..99
//  WEIGHTS     32'h05030201  packed 8-bit score weight per colour; byte k = colour k
// PORTS
//  clk         in   1            system clock
//  rst_n       in   1            asynchronous active-low reset
//  tick_1hz    in   1            one-clk-wide enable pulse, once per second
//  start_btn   in   1            debounced start level; the block edge-detects it
//  pause_btn   in   1            debounced pause level; the block edge-detects it
//  collision   in   NUM_ITEMS    per-channel landing pulse, one clk wide
//  color       in   2*NUM_ITEMS  colour of each channel; [2i+1:2i] = channel i
//  state       out  2            0=IDLE 1=PLAY 2=PAUSE 3=OVER
//  stop        out  1            1 in every state except PLAY
//  clear       out  1            one-clk pulse that resets the falling-item and stack blocks
//  score       out  SCORE_W      current score
//  sec_tens    out  4            remaining seconds, BCD tens digit
//  sec_ones    out  4            remaining seconds, BCD ones digit
//  end_game    out  1            1 while in OVER
//  hiscore     out  SCORE_W      best score seen since reset (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state=IDLE, stop=1, clear=0, score=0, end_game=0, hiscore=0,
//   sec_tens/sec_ones = ROUND_SECS in BCD.
//   Button edge-detect registers reset to 1, so a button held through reset is not seen as a press.
//  Rising edge of start_btn (registered detect), in any state:
//   next clk: clear=1 for exactly one cycle, score=0, timer reloads ROUND_SECS, state=PLAY.
//  Rising edge of pause_btn:
//   PLAY->PAUSE; PAUSE->PLAY; ignored in IDLE and OVER.
//  Start and pause rising edges in the same cycle: start wins and pause is discarded.
//  In PLAY only:
//   - tick_1hz decrements the BCD timer; ones wrap from 0 to 9 with a tens borrow.
//   - The tick that makes the timer 00 moves state to OVER in the same update.
//   - collision: each asserted channel i adds WEIGHTS[8*c+7:8*c], with c = color[2i+1:2i].
//   - All channels asserted in one cycle are summed in that cycle.
//   - The sum saturates at 2**SCORE_W-1. No wrap.
//  In IDLE, PAUSE and OVER: tick_1hz and collision are ignored; timer and score hold.
//  A collision in the same cycle as the final tick is scored; OVER is still entered.
//  Latency: button edge to state/clear change is 2 clk (sync register + state register).
//   collision to score update is 1 clk.
//  stop and end_game are decoded from the state register and are glitch-free.
//  Reset asserted mid-round returns all outputs to their reset values immediately.
// CONFIGURATION
//  HISCORE_EN defined:
//   - On the cycle OVER is entered, if score > hiscore then hiscore <= score.
//   - hiscore survives start_btn and is cleared only by rst_n.
//  HISCORE_EN undefined: hiscore is tied to 0 and no register is built.
// TESTING
//  1. Reset, then start edge -> clear high 1 cycle, state=1, timer=6/0 (defaults), score=0.
//  2. PLAY, 3 ticks -> timer 5/7; pause edge -> state=2; 5 ticks -> timer still 5/7; pause -> state=1.
//  3. NUM_ITEMS=2: collision=2'b11, colors 3 and 1 -> score +7 (5+2) in one clk.
//  4. SCORE_W=4, score=14, colour-3 collision -> score=15 (saturated), not 3.
//  5. ROUND_SECS=2, two ticks -> state=3, end_game=1, stop=1; further collision -> score unchanged.
//  6. HISCORE_EN: round 1 ends at 9, round 2 at 4 -> hiscore=9;
//     start and pause edges in the same clk -> PLAY, not PAUSE.

Source files
------------

// File: rtl/game_ctrl.sv
// Stacker game controller: IDLE/PLAY/PAUSE/OVER sequencing, BCD round timer and saturating score.
// Optional HISCORE_EN build adds a best-score register updated on round end.
module game_ctrl #(
    parameter int unsigned NUM_ITEMS  = 1,
    parameter int unsigned SCORE_W    = 7,
    parameter int unsigned ROUND_SECS = 60,
    parameter logic [31:0] WEIGHTS    = 32'h05030201
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_1hz,
    input  logic                   start_btn,
    input  logic                   pause_btn,
    input  logic [NUM_ITEMS-1:0]   collision,
    input  logic [2*NUM_ITEMS-1:0] color,
    output logic [1:0]             state,
    output logic                   stop,
    output logic                   clear,
    output logic [SCORE_W-1:0]     score,
    output logic [3:0]             sec_tens,
    output logic [3:0]             sec_ones,
    output logic                   end_game,
    output logic [SCORE_W-1:0]     hiscore
);

    // Eight channels of 8-bit weights sum to at most 11 bits; keep headroom above the score.
    localparam int unsigned SUM_W = SCORE_W + 12;
    localparam logic [3:0] RELOAD_TENS = 4'(ROUND_SECS / 10);
    localparam logic [3:0] RELOAD_ONES = 4'(ROUND_SECS % 10);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 start_prev_q, start_prev_d;
    logic                 pause_prev_q, pause_prev_d;
    logic                 start_evt_q, start_evt_d;
    logic                 pause_evt_q, pause_evt_d;
    logic                 clear_q, clear_d;
    logic                 stop_q, stop_d;
    logic                 end_game_q, end_game_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           tens_q, tens_d;
    logic [3:0]           ones_q, ones_d;
    logic [SUM_W-1:0]     col_sum;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

    // Button edge detection; the history flops reset high so a held button is not a press.
    always_comb begin
        start_prev_d = start_btn;
        pause_prev_d = pause_btn;
        start_evt_d  = start_btn & ~start_prev_q;
        pause_evt_d  = pause_btn & ~pause_prev_q;
    end

    // Weighted sum of all channels landing this cycle, saturated into the score range.
    always_comb begin
        col_sum = '0;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            if (collision[i]) begin
                col_sum = col_sum + SUM_W'(WEIGHTS[{color[2*i +: 2], 3'b000} +: 8]);
            end
        end
        score_sum = SUM_W'(score_q) + col_sum;
        score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    // Next-state, timer and score update.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        clear_d = 1'b0;
        if (start_evt_q) begin
            state_d = ST_PLAY;
            clear_d = 1'b1;
            score_d = '0;
            tens_d  = RELOAD_TENS;
            ones_d  = RELOAD_ONES;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (pause_evt_q) begin
                        state_d = ST_PAUSE;
                    end
                    score_d = score_sat;
                    if (tick_1hz) begin
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        if ((tens_d == 4'd0) && (ones_d == 4'd0)) begin
                            state_d = ST_OVER;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_evt_q) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
        stop_d     = (state_d != ST_PLAY);
        end_game_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
            start_evt_q  <= 1'b0;
            pause_evt_q  <= 1'b0;
            clear_q      <= 1'b0;
            stop_q       <= 1'b1;
            end_game_q   <= 1'b0;
            score_q      <= '0;
            tens_q       <= RELOAD_TENS;
            ones_q       <= RELOAD_ONES;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            start_evt_q  <= start_evt_d;
            pause_evt_q  <= pause_evt_d;
            clear_q      <= clear_d;
            stop_q       <= stop_d;
            end_game_q   <= end_game_d;
            score_q      <= score_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
        end
    end

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;

    // Capture the final score on the cycle the round ends.
    always_comb begin
        hiscore_d = hiscore_q;
        if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_d > hiscore_q)) begin
            hiscore_d = score_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

    assign state    = state_q;
    assign stop     = stop_q;
    assign clear    = clear_q;
    assign score    = score_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign end_game = end_game_q;

endmodule
